coeff_token_enc_neg2: RTL and testbench
=======================================

Name: coeff_token_enc_neg2

Overview:
- CAVLC coeff_token encoder for the nC = -2 table (chroma DC, 4:2:2). This is the transmit-side counterpart of the nC = -2 coeff_token decode ROM.
- Accepts one (TotalCoeff, TrailingOnes) symbol per valid/ready handshake, looks up its VLC codeword, and serialises it MSB-first, one bit per BitValid/BitReady handshake.
- Sits between the residual-block symbol generator and the bitstream packer.

Parameters:
- CNT_W, 16, width of the running emitted-bit counter BitCount; wraps modulo 2^CNT_W.
- ERR_STICKY, 0, 0 = Err is a one-cycle pulse per bad symbol; 1 = Err holds until reset.

Ports:
- Clk  in  1  rising-edge clock.
- nReset  in  1  asynchronous, active-low reset.
- InValid  in  1  symbol present.
- InReady  out  1  encoder can accept a symbol.
- TotalCoeff  in  5  total nonzero coefficients, legal range 0..8.
- TrailingOnes  in  2  trailing ±1 count, legal range 0..min(TotalCoeff,3).
- BitOut  out  1  current codeword bit.
- BitValid  out  1  BitOut is valid.
- BitReady  in  1  downstream consumes BitOut.
- LastBit  out  1  BitOut is the final bit of the codeword.
- Busy  out  1  serialisation in progress.
- Err  out  1  an illegal symbol was accepted.
- BitCount  out  CNT_W  total bits emitted since reset.

Behaviour:
- Reset values: InReady=1 once nReset deasserts. BitOut, BitValid, LastBit, Busy, Err = 0. BitCount=0. State=IDLE.
- Codeword table, written as TC/T1:code. Length equals the number of code characters.
  - 0/0:1
  - 1/0:0001111, 1/1:01
  - 2/0:0001110, 2/1:0001101, 2/2:001
  - 3/0:000000111, 3/1:0001100, 3/2:0001011, 3/3:00001
  - 4/0:000000110, 4/1:000000101, 4/2:0001010, 4/3:000001
  - 5/0:0000000111, 5/1:0000000110, 5/2:000000100, 5/3:0001001
  - 6/0:00000000111, 6/1:00000000110, 6/2:0000000101, 6/3:0001000
  - 7/0:000000000111, 7/1:000000000110, 7/2:00000000101, 7/3:0000000100
  - 8/0:0000000000111, 8/1:000000000101, 8/2:000000000100, 8/3:00000000100
  - Maximum length is 13.
- States: IDLE and SHIFT. InReady = (state==IDLE). Busy = (state==SHIFT).
- IDLE with InValid=1, legal symbol:
  - Load a 13-bit shift register with the codeword left-aligned and a 4-bit remaining count with its length.
  - Go to SHIFT.
  - The first bit appears on BitOut with BitValid=1 in the cycle after acceptance (latency 1).
- IDLE with InValid=1, illegal symbol (TC>8, or T1>TC):
  - The symbol is consumed and no bits are emitted.
  - Err=1 in the next cycle, then behaves per ERR_STICKY. State stays IDLE.
- SHIFT:
  - BitOut = shreg[12]. LastBit = (remaining==1).
  - On BitValid&BitReady: shift left by 1, decrement remaining, increment BitCount.
  - If LastBit, go to IDLE with BitValid=0 in the following cycle.
  - While BitReady=0, BitOut, LastBit and the shift state hold exactly (no bit loss or duplication).
- Throughput: len+1 cycles per symbol with BitReady held high. The single IDLE cycle between codewords is required.
- InValid is ignored in SHIFT. Symbol inputs are sampled only on an InValid&InReady cycle.
- BitCount wraps from 2^CNT_W-1 to 0 with no flag.
- nReset asserted mid-codeword aborts it immediately. All outputs return to reset values asynchronously, and the partial codeword is discarded.
- All outputs are registered except InReady, Busy and LastBit, which are decoded from state and count.

Test Plan:
- Reset then TC=0,T1=0, BitReady=1 → BitValid one cycle at T+1, BitOut=1, LastBit=1, BitCount=1, InReady high again at T+2.
- TC=8,T1=0 → 13 bits 0000000000111, LastBit on 13th only, BitCount=13; then TC=1,T1=1 → bits 0,1, BitCount=15.
- All 30 legal (TC,T1) pairs back-to-back with random BitReady stalls → the concatenated bitstream decodes via the nC=-2 decode ROM to the same symbol sequence, with matching NumShift.
- TC=2,T1=3 and TC=9,T1=0 → no BitValid, Err pulses one cycle each (ERR_STICKY=0); with ERR_STICKY=1 Err stays 1 until reset.
- TC=5,T1=0 (0000000111) with BitReady low for 4 cycles after the 3rd bit → BitOut held at 0, BitCount frozen at 3, then the remaining 7 bits are emitted correctly.
- nReset pulsed low after the 4th bit of TC=7,T1=1 → BitValid=0 and BitCount=0 immediately; the next TC=3,T1=3 emits exactly 00001.

Source files
------------

// File: rtl/coeff_token_enc_neg2.sv
// coeff_token_enc_neg2: CAVLC coeff_token encoder for the nC = -2 table
// (chroma DC, 4:2:2). It accepts one (TotalCoeff, TrailingOnes) symbol per
// handshake, looks up the codeword, and sends it MSB-first, one bit per
// BitValid/BitReady handshake. An illegal symbol is consumed and raises Err.
module coeff_token_enc_neg2 #(
    parameter int CNT_W      = 16,
    parameter bit ERR_STICKY = 1'b0
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [4:0]       TotalCoeff,
    input  logic [1:0]       TrailingOnes,
    output logic             BitOut,
    output logic             BitValid,
    input  logic             BitReady,
    output logic             LastBit,
    output logic             Busy,
    output logic             Err,
    output logic [CNT_W-1:0] BitCount
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [12:0]      shreg_q, shreg_d;
    logic [3:0]       rem_q, rem_d;
    logic             bit_valid_q, bit_valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;

    logic             sym_legal;
    logic [3:0]       code_len;
    logic [12:0]      code_val;
    logic [12:0]      code_aligned;

    // Codeword ROM: right-aligned value and length for every legal symbol.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (otherwise a latch is inferred).
    always_comb begin
        code_val  = 13'd0;
        code_len  = 4'd0;
        sym_legal = (TotalCoeff <= 5'd8) && ({3'b000, TrailingOnes} <= TotalCoeff);
        case ({TotalCoeff[3:0], TrailingOnes})
            {4'd0, 2'd0}: begin code_val = 13'd1;  code_len = 4'd1;  end
            {4'd1, 2'd0}: begin code_val = 13'd15; code_len = 4'd7;  end
            {4'd1, 2'd1}: begin code_val = 13'd1;  code_len = 4'd2;  end
            {4'd2, 2'd0}: begin code_val = 13'd14; code_len = 4'd7;  end
            {4'd2, 2'd1}: begin code_val = 13'd13; code_len = 4'd7;  end
            {4'd2, 2'd2}: begin code_val = 13'd1;  code_len = 4'd3;  end
            {4'd3, 2'd0}: begin code_val = 13'd7;  code_len = 4'd9;  end
            {4'd3, 2'd1}: begin code_val = 13'd12; code_len = 4'd7;  end
            {4'd3, 2'd2}: begin code_val = 13'd11; code_len = 4'd7;  end
            {4'd3, 2'd3}: begin code_val = 13'd1;  code_len = 4'd5;  end
            {4'd4, 2'd0}: begin code_val = 13'd6;  code_len = 4'd9;  end
            {4'd4, 2'd1}: begin code_val = 13'd5;  code_len = 4'd9;  end
            {4'd4, 2'd2}: begin code_val = 13'd10; code_len = 4'd7;  end
            {4'd4, 2'd3}: begin code_val = 13'd1;  code_len = 4'd6;  end
            {4'd5, 2'd0}: begin code_val = 13'd7;  code_len = 4'd10; end
            {4'd5, 2'd1}: begin code_val = 13'd6;  code_len = 4'd10; end
            {4'd5, 2'd2}: begin code_val = 13'd4;  code_len = 4'd9;  end
            {4'd5, 2'd3}: begin code_val = 13'd9;  code_len = 4'd7;  end
            {4'd6, 2'd0}: begin code_val = 13'd7;  code_len = 4'd11; end
            {4'd6, 2'd1}: begin code_val = 13'd6;  code_len = 4'd11; end
            {4'd6, 2'd2}: begin code_val = 13'd5;  code_len = 4'd10; end
            {4'd6, 2'd3}: begin code_val = 13'd8;  code_len = 4'd7;  end
            {4'd7, 2'd0}: begin code_val = 13'd7;  code_len = 4'd12; end
            {4'd7, 2'd1}: begin code_val = 13'd6;  code_len = 4'd12; end
            {4'd7, 2'd2}: begin code_val = 13'd5;  code_len = 4'd11; end
            {4'd7, 2'd3}: begin code_val = 13'd4;  code_len = 4'd10; end
            {4'd8, 2'd0}: begin code_val = 13'd7;  code_len = 4'd13; end
            {4'd8, 2'd1}: begin code_val = 13'd5;  code_len = 4'd12; end
            {4'd8, 2'd2}: begin code_val = 13'd4;  code_len = 4'd12; end
            {4'd8, 2'd3}: begin code_val = 13'd4;  code_len = 4'd11; end
            default:      begin code_val = 13'd0;  code_len = 4'd0;  end
        endcase
        // Left-align so the first codeword bit sits at shreg[12].
        code_aligned = code_val << (4'd13 - code_len);
    end

    // Next-state logic: accept/load in IDLE, shift one bit per handshake in SHIFT.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        rem_d       = rem_q;
        bit_count_d = bit_count_q;
        err_d       = ERR_STICKY ? err_q : 1'b0;
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    if (sym_legal) begin
                        shreg_d = code_aligned;
                        rem_d   = code_len;
                        state_d = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bit_valid_q && BitReady) begin
                    shreg_d     = {shreg_q[11:0], 1'b0};
                    rem_d       = rem_q - 4'd1;
                    bit_count_d = bit_count_q + CNT_ONE;
                    if (rem_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        bit_valid_d = (state_d == SHIFT);
    end

    // State and datapath registers; reset aborts any codeword in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            shreg_q     <= 13'd0;
            rem_q       <= 4'd0;
            bit_valid_q <= 1'b0;
            err_q       <= 1'b0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            rem_q       <= rem_d;
            bit_valid_q <= bit_valid_d;
            err_q       <= err_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign InReady  = (state_q == IDLE);
    assign Busy     = (state_q == SHIFT);
    assign LastBit  = (state_q == SHIFT) && (rem_q == 4'd1);
    assign BitOut   = shreg_q[12];
    assign BitValid = bit_valid_q;
    assign Err      = err_q;
    assign BitCount = bit_count_q;

endmodule

// File: tb/tb_coeff_token_enc_neg2.sv
// Testbench for coeff_token_enc_neg2. Two instances share all inputs: one
// with default parameters, one with ERR_STICKY=1 and a 4-bit BitCount to
// exercise sticky Err and counter wrap.
module tb_coeff_token_enc_neg2;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        in_valid;
    logic [4:0]  tc;
    logic [1:0]  t1;
    logic        bit_ready;

    logic        in_ready, bit_out, bit_valid, last_bit, busy, err;
    logic [15:0] bit_count;
    logic        s_in_ready, s_bit_out, s_bit_valid, s_last_bit, s_busy, s_err;
    logic [3:0]  s_bit_count;

    int errors = 0;
    int checks = 0;

    // Reference model state: codeword strings, bits emitted, symbols sent.
    string       code_tab[36];
    int unsigned model_bits;
    bit          stream_q[$];
    int          sym_q[$];

    typedef struct {
        int    tc;
        int    t1;
        int    stall_at;
        int    stall_n;
        string code;
        bit    err;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    coeff_token_enc_neg2 #(.CNT_W(16), .ERR_STICKY(1'b0)) dut (
        .Clk(clk), .nReset(n_reset), .InValid(in_valid), .InReady(in_ready),
        .TotalCoeff(tc), .TrailingOnes(t1), .BitOut(bit_out), .BitValid(bit_valid),
        .BitReady(bit_ready), .LastBit(last_bit), .Busy(busy), .Err(err),
        .BitCount(bit_count)
    );

    coeff_token_enc_neg2 #(.CNT_W(4), .ERR_STICKY(1'b1)) dut_s (
        .Clk(clk), .nReset(n_reset), .InValid(in_valid), .InReady(s_in_ready),
        .TotalCoeff(tc), .TrailingOnes(t1), .BitOut(s_bit_out), .BitValid(s_bit_valid),
        .BitReady(bit_ready), .LastBit(s_last_bit), .Busy(s_busy), .Err(s_err),
        .BitCount(s_bit_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input int c, input int o);
        return (c <= 8) && (o <= c);
    endfunction

    // Send one symbol and drain its codeword, comparing every bit to exp_code.
    task automatic apply_symbol(input int tc_i, input int t1_i, input string exp_code,
                                input bit exp_err, input int stall_pct,
                                input int stall_at, input int stall_n);
        int len = exp_code.len();
        int idx = 0;
        int cycles = 0;
        int n = 0;
        int n_stall = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        tc       = tc_i[4:0];
        t1       = t1_i[1:0];
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tc       = 5'($urandom);
        t1       = 2'($urandom);
        if (exp_err) begin
            check("err_pulse", err, 1);
            check("err_sticky_set", s_err, 1);
            check("no_bits_on_err", {bit_valid, in_ready}, 2'b01);
            @(negedge clk);
            check("err_clears", err, 0);
            check("err_sticky_holds", s_err, 1);
            check("idle_after_err", {bit_valid, busy}, 2'b00);
            return;
        end
        sym_q.push_back(tc_i * 4 + t1_i);
        while (idx < len && cycles < 400) begin
            check("bit", {bit_valid, bit_out, last_bit, busy, in_ready},
                  {1'b1, (exp_code[idx] == 8'h31), (idx == len - 1), 1'b1, 1'b0});
            if (idx == stall_at && n_stall < stall_n) begin
                bit_ready = 1'b0;
                n_stall++;
                check("stall_count_frozen", bit_count, model_bits[15:0]);
            end else begin
                bit_ready = ($urandom_range(99) >= stall_pct);
            end
            // Junk symbols during SHIFT must be ignored.
            in_valid = 1'($urandom_range(1));
            tc       = 5'($urandom);
            if (bit_ready) begin
                stream_q.push_back(exp_code[idx] == 8'h31);
                idx++;
                model_bits++;
            end
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        if (idx < len) check("shift_timeout", idx, len);
        check("idle_after_code", {bit_valid, busy, in_ready}, 3'b001);
        check("bit_count", bit_count, model_bits[15:0]);
        check("bit_count_wrap", s_bit_count, model_bits[3:0]);
        check("no_err", err, 0);
    endtask

    // Parse the captured bitstream with the code table and compare symbols.
    task automatic decode_check();
        string acc = "";
        int    got[$];
        foreach (stream_q[i]) begin
            acc = {acc, stream_q[i] ? "1" : "0"};
            for (int k = 0; k < 36; k++) begin
                if (acc == code_tab[k]) begin
                    got.push_back(k);
                    acc = "";
                    break;
                end
            end
        end
        check("decode_count", got.size(), sym_q.size());
        check("decode_tail", acc.len(), 0);
        for (int i = 0; i < got.size() && i < sym_q.size(); i++)
            check("decode_sym", got[i], sym_q[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int keys[30];
        int nk;
        int c, o;

        foreach (code_tab[i]) code_tab[i] = "";
        code_tab[0]  = "1";
        code_tab[4]  = "0001111";       code_tab[5]  = "01";
        code_tab[8]  = "0001110";       code_tab[9]  = "0001101";
        code_tab[10] = "001";
        code_tab[12] = "000000111";     code_tab[13] = "0001100";
        code_tab[14] = "0001011";       code_tab[15] = "00001";
        code_tab[16] = "000000110";     code_tab[17] = "000000101";
        code_tab[18] = "0001010";       code_tab[19] = "000001";
        code_tab[20] = "0000000111";    code_tab[21] = "0000000110";
        code_tab[22] = "000000100";     code_tab[23] = "0001001";
        code_tab[24] = "00000000111";   code_tab[25] = "00000000110";
        code_tab[26] = "0000000101";    code_tab[27] = "0001000";
        code_tab[28] = "000000000111";  code_tab[29] = "000000000110";
        code_tab[30] = "00000000101";   code_tab[31] = "0000000100";
        code_tab[32] = "0000000000111"; code_tab[33] = "000000000101";
        code_tab[34] = "000000000100";  code_tab[35] = "00000000100";

        vecs.push_back('{tc: 8,  t1: 0, stall_at: -1, stall_n: 0, code: "0000000000111", err: 1'b0});
        vecs.push_back('{tc: 1,  t1: 1, stall_at: -1, stall_n: 0, code: "01",            err: 1'b0});
        vecs.push_back('{tc: 2,  t1: 3, stall_at: -1, stall_n: 0, code: "",              err: 1'b1});
        vecs.push_back('{tc: 9,  t1: 0, stall_at: -1, stall_n: 0, code: "",              err: 1'b1});
        vecs.push_back('{tc: 5,  t1: 0, stall_at: 3,  stall_n: 4, code: "0000000111",    err: 1'b0});
        vecs.push_back('{tc: 3,  t1: 3, stall_at: -1, stall_n: 0, code: "00001",         err: 1'b0});
        vecs.push_back('{tc: 4,  t1: 2, stall_at: 0,  stall_n: 2, code: "0001010",       err: 1'b0});
        vecs.push_back('{tc: 31, t1: 3, stall_at: -1, stall_n: 0, code: "",              err: 1'b1});

        // Reset state.
        n_reset = 1'b0; in_valid = 1'b0; bit_ready = 1'b0; tc = 5'd0; t1 = 2'd0;
        model_bits = 0;
        #12;
        check("reset_outputs", {bit_out, bit_valid, last_bit, busy, err}, 5'b0);
        check("reset_bit_count", bit_count, 0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);

        // Shortest codeword: latency 1, one-cycle BitValid, IDLE at T+2.
        tc = 5'd0; t1 = 2'd0; in_valid = 1'b1; bit_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("first_bit", {bit_valid, bit_out, last_bit, in_ready}, 4'b1110);
        @(negedge clk);
        check("first_done", {bit_valid, in_ready}, 2'b01);
        check("first_count", bit_count, 1);
        model_bits = 1;
        stream_q.push_back(1'b1);
        sym_q.push_back(0);

        // Directed table vectors.
        for (int i = 0; i < vecs.size(); i++)
            apply_symbol(vecs[i].tc, vecs[i].t1, vecs[i].code, vecs[i].err, 0,
                         vecs[i].stall_at, vecs[i].stall_n);

        repeat (3) @(negedge clk);
        check("sticky_err_persist", {s_err, err}, 2'b10);

        // All 30 legal symbols in shuffled order with random stalls.
        nk = 0;
        for (int a = 0; a <= 8; a++)
            for (int b = 0; b <= 3; b++)
                if (is_legal(a, b)) begin keys[nk] = a * 4 + b; nk++; end
        for (int i = nk - 1; i > 0; i--) begin
            int j = $urandom_range(i);
            int tmp = keys[i];
            keys[i] = keys[j];
            keys[j] = tmp;
        end
        for (int i = 0; i < nk; i++)
            apply_symbol(keys[i] / 4, keys[i] % 4, code_tab[keys[i]], 1'b0, 30, -1, 0);

        // Random symbols, legal and illegal.
        for (int i = 0; i < 40; i++) begin
            c = $urandom_range(11);
            o = $urandom_range(3);
            if (is_legal(c, o))
                apply_symbol(c, o, code_tab[c * 4 + o], 1'b0, 40, -1, 0);
            else
                apply_symbol(c, o, "", 1'b1, 0, -1, 0);
        end

        decode_check();

        // Reset in the middle of TC=7,T1=1 after its 4th bit.
        @(negedge clk);
        tc = 5'd7; t1 = 2'd1; in_valid = 1'b1; bit_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_code_count", bit_count, 16'(model_bits + 4));
        n_reset = 1'b0;
        #1;
        check("abort_outputs", {bit_valid, busy, last_bit, err}, 4'b0);
        check("abort_count", bit_count, 0);
        check("abort_sticky", {s_err, s_bit_count}, 5'b0);
        @(negedge clk);
        n_reset = 1'b1;
        model_bits = 0;
        stream_q.delete();
        sym_q.delete();
        @(negedge clk);
        apply_symbol(3, 3, "00001", 1'b0, 0, -1, 0);
        decode_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
